// File: rtl/pc_gen.sv
// Program counter generator: issues sequential fetch requests, applies branch/JALR redirects
// from the branch stage, holds a request stable until accepted, and traps on misaligned targets.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        pc_asrc,
  input  logic        pc_bsrc,
  input  logic [31:0] ex_pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] imm,
  input  logic        stall,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        misalign,
  output logic [31:0] misalign_addr
);

  typedef enum logic [1:0] {StIdle, StRun, StPend, StTrap} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        hold_q, hold_d;
  logic [31:0] pend_q, pend_d;
  logic        mis_q, mis_d;
  logic [31:0] mis_addr_q, mis_addr_d;

  logic        redirect;
  logic        handshake;
  logic [31:0] base;
  logic [31:0] sum;
  logic [31:0] target;
  logic        target_misaligned;

  assign redirect          = ex_valid & pc_asrc;
  assign base              = pc_bsrc ? rs1_data : ex_pc;
  assign sum               = base + imm;
  // JALR targets drop bit 0; bit 1 can still leave the target misaligned.
  assign target            = pc_bsrc ? {sum[31:1], 1'b0} : sum;
  assign target_misaligned = |target[1:0];

  // A held request stays valid through stalls and redirects until it is accepted.
  assign if_req_valid = hold_q | (((state_q == StRun) | (state_q == StPend)) & ~stall);
  assign handshake    = if_req_valid & if_req_ready;

  assign if_pc         = pc_q;
  assign misalign      = mis_q;
  assign misalign_addr = mis_addr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    mis_d      = mis_q;
    mis_addr_d = mis_addr_q;
    flush      = 1'b0;

    if (if_req_ready) begin
      hold_d = 1'b0;
    end else if (if_req_valid) begin
      hold_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end

    case (state_q)
      StIdle: begin
        state_d = StRun;
      end
      StRun: begin
        if (redirect) begin
          flush = 1'b1;
          if (target_misaligned) begin
            mis_d      = 1'b1;
            mis_addr_d = target;
            state_d    = StTrap;
          end else if (if_req_valid && !if_req_ready) begin
            // The outstanding request must keep its address; apply the target after acceptance.
            pend_d  = target;
            state_d = StPend;
          end else begin
            pc_d = target;
          end
        end else if (handshake) begin
          pc_d = pc_q + 32'd4;
        end
      end
      StPend: begin
        if (handshake) begin
          pc_d    = pend_q;
          state_d = StRun;
        end
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      hold_q     <= 1'b0;
      pend_q     <= 32'h0000_0000;
      mis_q      <= 1'b0;
      mis_addr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations, then a random
// phase, all continuously compared against a behavioural model of the fetch-address rules.
module tb_pc_gen;

  localparam logic [31:0] RPC = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        pc_asrc;
  logic        pc_bsrc;
  logic [31:0] ex_pc;
  logic [31:0] rs1_data;
  logic [31:0] imm;
  logic        stall;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_pc;
  logic        flush;
  logic        misalign;
  logic [31:0] misalign_addr;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .pc_asrc      (pc_asrc),
    .pc_bsrc      (pc_bsrc),
    .ex_pc        (ex_pc),
    .rs1_data     (rs1_data),
    .imm          (imm),
    .stall        (stall),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_pc        (if_pc),
    .flush        (flush),
    .misalign     (misalign),
    .misalign_addr(misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = waiting first cycle after reset, 1 = fetching, 2 = redirect pending,
  // 3 = trapped. Expected outputs are derived from the rules each negedge.
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_pending;
  bit          m_mis;
  logic [31:0] m_mis_addr;
  bit          model_ok = 0;

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit          e_valid;
        bit          e_flush;
        bit          red;
        logic [31:0] t;
        e_valid = m_held || ((m_mode == 1 || m_mode == 2) && !stall);
        red     = ex_valid && pc_asrc;
        e_flush = (m_mode == 1) && red;
        if (pc_bsrc) begin
          t = rs1_data + imm;
          t = t - (t % 2);
        end else begin
          t = ex_pc + imm;
        end
        if (model_ok) begin
          chk("model_valid", {31'd0, if_req_valid}, {31'd0, e_valid});
          chk("model_pc", if_pc, m_pc);
          chk("model_flush", {31'd0, flush}, {31'd0, e_flush});
          chk("model_misalign", {31'd0, misalign}, {31'd0, m_mis});
          chk("model_misalign_addr", misalign_addr, m_mis_addr);
        end
        if (rst) begin
          m_mode = 0; m_pc = RPC; m_held = 0; m_pending = 0; m_mis = 0; m_mis_addr = 0;
          model_ok = 1;
        end else begin
          if (m_mode == 0) begin
            m_mode = 1;
          end else if (m_mode == 1) begin
            if (red && (t % 4) != 0) begin
              m_mis = 1; m_mis_addr = t; m_mode = 3;
            end else if (red && e_valid && !if_req_ready) begin
              m_pending = t; m_mode = 2;
            end else if (red) begin
              m_pc = t;
            end else if (e_valid && if_req_ready) begin
              m_pc = m_pc + 4;
            end
          end else if (m_mode == 2) begin
            if (e_valid && if_req_ready) begin
              m_pc = m_pending; m_mode = 1;
            end
          end
          m_held = e_valid && !if_req_ready;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic set_redirect(input bit v, input bit bsrc, input logic [31:0] epc,
                              input logic [31:0] rs1, input logic [31:0] off);
    ex_valid = v; pc_asrc = 1'b1; pc_bsrc = bsrc; ex_pc = epc; rs1_data = rs1; imm = off;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; pc_asrc = 1'b0; pc_bsrc = 1'b0; ex_pc = '0;
    rs1_data = '0; imm = '0; stall = 1'b0; if_req_ready = 1'b1;
    next_cycle(); next_cycle();
    rst = 1'b0;
    at_sample();
    chk("idle_valid", {31'd0, if_req_valid}, 32'd0);
    chk("idle_flush", {31'd0, flush}, 32'd0);
    next_cycle(); at_sample();
    chk("seq_pc0", if_pc, 32'h1000);
    chk("seq_valid0", {31'd0, if_req_valid}, 32'd1);
    next_cycle(); at_sample(); chk("seq_pc1", if_pc, 32'h1004);
    next_cycle(); at_sample(); chk("seq_pc2", if_pc, 32'h1008);

    // Redirect while the request at 100C is not accepted.
    next_cycle();
    if_req_ready = 1'b0;
    set_redirect(1'b1, 1'b1, 32'h0, 32'h2001, 32'h3);
    at_sample();
    chk("pend_flush", {31'd0, flush}, 32'd1);
    chk("pend_pc_held", if_pc, 32'h100C);
    next_cycle();
    stall = 1'b1;
    set_redirect(1'b1, 1'b0, 32'h1008, 32'h0, 32'h20);
    at_sample();
    chk("pend_ignore_flush", {31'd0, flush}, 32'd0);
    chk("hold_stall_valid", {31'd0, if_req_valid}, 32'd1);
    chk("hold_stall_pc", if_pc, 32'h100C);
    next_cycle();
    ex_valid = 1'b0; stall = 1'b0; if_req_ready = 1'b1;
    at_sample(); chk("pend_accept_pc", if_pc, 32'h100C);
    next_cycle();
    set_redirect(1'b1, 1'b0, 32'h1008, 32'h0, 32'h20);
    at_sample();
    chk("pend_target_pc", if_pc, 32'h2004);
    chk("branch_flush", {31'd0, flush}, 32'd1);
    next_cycle();
    ex_valid = 1'b0; stall = 1'b1;
    at_sample();
    chk("branch_pc", if_pc, 32'h1028);
    chk("stall_valid", {31'd0, if_req_valid}, 32'd0);
    next_cycle();
    stall = 1'b0; pc_asrc = 1'b1; ex_valid = 1'b0;
    at_sample();
    chk("stall_pc_kept", if_pc, 32'h1028);
    chk("exvalid0_flush", {31'd0, flush}, 32'd0);

    // Misaligned target traps.
    next_cycle();
    set_redirect(1'b1, 1'b0, 32'h1000, 32'h0, 32'h6);
    at_sample();
    chk("mis_pc", if_pc, 32'h102C);
    chk("mis_flush", {31'd0, flush}, 32'd1);
    next_cycle();
    set_redirect(1'b1, 1'b0, 32'h1000, 32'h0, 32'h20);
    at_sample();
    chk("trap_misalign", {31'd0, misalign}, 32'd1);
    chk("trap_addr", misalign_addr, 32'h1006);
    chk("trap_pc", if_pc, 32'h102C);
    chk("trap_flush", {31'd0, flush}, 32'd0);
    chk("trap_valid", {31'd0, if_req_valid}, 32'd0);
    next_cycle(); ex_valid = 1'b0;
    at_sample(); chk("trap_sticky", {31'd0, misalign}, 32'd1);
    next_cycle(); rst = 1'b1; at_sample();
    next_cycle(); rst = 1'b0; at_sample();
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_pc", if_pc, 32'h1000);
    chk("rst_valid", {31'd0, if_req_valid}, 32'd0);

    // Wrap at the top of the address space, then reset while pending.
    next_cycle();
    set_redirect(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'hC);
    at_sample(); chk("wrap_flush", {31'd0, flush}, 32'd1);
    next_cycle(); ex_valid = 1'b0;
    at_sample(); chk("wrap_top", if_pc, 32'hFFFF_FFFC);
    next_cycle(); at_sample(); chk("wrap_zero", if_pc, 32'h0);
    next_cycle();
    if_req_ready = 1'b0;
    set_redirect(1'b1, 1'b0, 32'h0, 32'h0, 32'h40);
    at_sample();
    chk("wrap_next", if_pc, 32'h4);
    chk("pend2_flush", {31'd0, flush}, 32'd1);
    next_cycle(); ex_valid = 1'b0; rst = 1'b1;
    at_sample(); chk("pend2_valid", {31'd0, if_req_valid}, 32'd1);
    next_cycle(); rst = 1'b0; if_req_ready = 1'b1;
    at_sample();
    chk("pend_rst_pc", if_pc, 32'h1000);
    chk("pend_rst_valid", {31'd0, if_req_valid}, 32'd0);
    next_cycle(); at_sample(); chk("pend_rst_run", if_pc, 32'h1000);
    next_cycle(); at_sample(); chk("pend_discarded", if_pc, 32'h1004);

    // Random traffic, checked by the model.
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      rst          = ($urandom_range(0, 39) == 0);
      if_req_ready = ($urandom_range(0, 2) != 0);
      stall        = ($urandom_range(0, 3) == 0);
      ex_valid     = ($urandom_range(0, 3) == 0);
      pc_asrc      = ($urandom_range(0, 1) == 1);
      pc_bsrc      = ($urandom_range(0, 1) == 1);
      ex_pc        = {$urandom_range(0, 255), 2'b00};
      rs1_data     = $urandom;
      imm          = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7)
                                                  : {$urandom_range(0, 63), 2'b00};
    end
    next_cycle();
    rst = 1'b0; ex_valid = 1'b0;
    at_sample();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
